// File: rtl/gf2m_dot_seq_if.sv
// ---------------------------------------------------------------------------
// gf2m_dot_seq_if
//
// Bundles the request, operand-memory and multiplier signals of
// gf2m_dot_seq. Clock and reset are plain ports on the engine itself.
//
//   slave  : the dot-product engine (gf2m_dot_seq)
//   master : its environment (requester, operand memory, multiplier)
//
// Signals:
//   start, len           request to run a dot product of len elements
//   busy, done, result   engine status and the XOR-sum of a[i]*b[i]
//   rd_en, rd_addr       operand memory read strobe and index
//   rd_a_data, rd_b_data operands a[i], b[i], valid one cycle after rd_en
//   mul_start            one-cycle start pulse to the GF(2^m) multiplier
//   mul_op_a, mul_op_b   multiplier operands, stable until mul_done
//   mul_done, mul_op_c   multiplier completion pulse and product
// ---------------------------------------------------------------------------
interface gf2m_dot_seq_if #(
  parameter int WIDTH  = 83,
  parameter int ADDR_W = 6
);
  logic              start;
  logic [ADDR_W-1:0] len;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_a_data;
  logic [WIDTH-1:0]  rd_b_data;
  logic              mul_start;
  logic [WIDTH-1:0]  mul_op_a;
  logic [WIDTH-1:0]  mul_op_b;
  logic              mul_done;
  logic [WIDTH-1:0]  mul_op_c;

  modport slave (
    input  start, len, rd_a_data, rd_b_data, mul_done, mul_op_c,
    output busy, done, result, rd_en, rd_addr, mul_start, mul_op_a, mul_op_b
  );

  modport master (
    output start, len, rd_a_data, rd_b_data, mul_done, mul_op_c,
    input  busy, done, result, rd_en, rd_addr, mul_start, mul_op_a, mul_op_b
  );
endinterface

// File: rtl/gf2m_dot_seq.sv
// ---------------------------------------------------------------------------
// gf2m_dot_seq
//
// Sequential GF(2^WIDTH) dot product: result = XOR over i < len of
// a[i]*b[i]. Operands are read from an external memory with one cycle of
// read latency. Each product comes from an external multiplier driven
// through a start/done handshake.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  gf2m_dot_seq_if.slave, carrying start/len/busy/done/result, the
//        rd_* memory port and the mul_* multiplier port
//
// Optional feature (macro GF2M_DOT_PREFETCH_EN):
//   While element i is being multiplied, element i+1 is read into a
//   prefetch register. On mul_done the multiplier operands reload from
//   that register, which skips the FETCH/LOAD round trip. If the prefetch
//   has not landed by mul_done, the normal FETCH path is used instead.
//   The result is the same with and without the feature.
// ---------------------------------------------------------------------------
module gf2m_dot_seq #(
  parameter int WIDTH  = 83,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                rst,
  gf2m_dot_seq_if.slave       bus
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] len_q;
  logic [ADDR_W-1:0] idx;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  result_q;
  logic              busy_q;
  logic              done_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              mul_start_q;
  logic [WIDTH-1:0]  op_a_q;
  logic [WIDTH-1:0]  op_b_q;
  logic [ADDR_W-1:0] idx_nxt;

`ifdef GF2M_DOT_PREFETCH_EN
  logic [WIDTH-1:0]  pf_a;
  logic [WIDTH-1:0]  pf_b;
  logic              pf_pend;  // prefetch read data arrives this cycle
  logic              pf_full;  // prefetch register holds element idx+1
  logic              pf_hit;   // LOAD must keep the operands taken from pf_*
`endif

  // Termination compares idx+1 against len, so idx never wraps.
  assign idx_nxt = idx + 1'b1;

  // NOTE: all state here is sequential and uses non-blocking assignments,
  // so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      len_q       <= '0;
      idx         <= '0;
      acc         <= '0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      mul_start_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
`ifdef GF2M_DOT_PREFETCH_EN
      pf_a        <= '0;
      pf_b        <= '0;
      pf_pend     <= 1'b0;
      pf_full     <= 1'b0;
      pf_hit      <= 1'b0;
`endif
    end else begin
      // NOTE: strobes default low every cycle; a state raises one only for
      // the single cycle it is needed, which makes every strobe a one-cycle pulse.
      done_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      mul_start_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            len_q  <= bus.len;
            idx    <= '0;
            acc    <= '0;
            busy_q <= 1'b1;
            if (bus.len == '0) begin
              state <= FIN;
            end else begin
              state     <= FETCH;
              rd_en_q   <= 1'b1;
              rd_addr_q <= '0;
            end
          end
        end

        // rd_en was raised on entry; the read data is valid during LOAD.
        FETCH: state <= LOAD;

        LOAD: begin
`ifdef GF2M_DOT_PREFETCH_EN
          if (!pf_hit) begin
            op_a_q <= bus.rd_a_data;
            op_b_q <= bus.rd_b_data;
          end
          pf_hit <= 1'b0;
`else
          op_a_q <= bus.rd_a_data;
          op_b_q <= bus.rd_b_data;
`endif
          mul_start_q <= 1'b1;
          state       <= WAIT;
        end

        WAIT: begin
`ifdef GF2M_DOT_PREFETCH_EN
          // Issue the read of element idx+1 in the cycle after mul_start,
          // but never beyond the last element.
          if (mul_start_q && (idx_nxt != len_q)) begin
            rd_en_q   <= 1'b1;
            rd_addr_q <= idx_nxt;
          end
          pf_pend <= rd_en_q;
          if (pf_pend) begin
            pf_a    <= bus.rd_a_data;
            pf_b    <= bus.rd_b_data;
            pf_full <= 1'b1;
          end
`endif
          if (bus.mul_done) begin
            acc <= acc ^ bus.mul_op_c;
            idx <= idx_nxt;
            if (idx_nxt == len_q) begin
              state <= FIN;
`ifdef GF2M_DOT_PREFETCH_EN
            end else if (pf_full) begin
              op_a_q <= pf_a;
              op_b_q <= pf_b;
              pf_hit <= 1'b1;
              state  <= LOAD;
`endif
            end else begin
              state     <= FETCH;
              rd_en_q   <= 1'b1;
              rd_addr_q <= idx_nxt;
            end
`ifdef GF2M_DOT_PREFETCH_EN
            pf_full <= 1'b0;
            pf_pend <= 1'b0;
`endif
          end
        end

        FIN: begin
          result_q <= acc;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.rd_en     = rd_en_q;
  assign bus.rd_addr   = rd_addr_q;
  assign bus.mul_start = mul_start_q;
  assign bus.mul_op_a  = op_a_q;
  assign bus.mul_op_b  = op_b_q;

endmodule

// File: tb/tb_gf2m_dot_seq.sv
// ---------------------------------------------------------------------------
// tb_gf2m_dot_seq
//
// Bench for gf2m_dot_seq. It provides an 8-entry operand memory with one
// cycle of read latency and a stub GF(2^83) multiplier. The stub raises
// mul_done in the LM-th cycle, counting the mul_start cycle as cycle 1.
// The reduction polynomial is x^83 + x^7 + x^4 + x^2 + 1.
// Stimulus pushes the hand-computed result and timing into a scoreboard
// queue. A negedge monitor pops one entry for each done pulse.
// ---------------------------------------------------------------------------
module tb_gf2m_dot_seq;
  localparam int WIDTH  = 83;
  localparam int ADDR_W = 6;
  localparam int LM     = 8;  // the stub needs LM >= 3
  localparam logic [WIDTH-1:0] POLY_LOW = 83'h95;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               t0;
    int               lat;
    int               nrd;
    int               nms;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gf2m_dot_seq_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  gf2m_dot_seq #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   rd_seen  = 0;
  int   ms_seen  = 0;
  exp_t sb[$];
  exp_t e;

  logic [WIDTH-1:0] mem_a [8];
  logic [WIDTH-1:0] mem_b [8];
  logic             stub_done = 1'b0;
  logic             inj_done;
  logic [WIDTH-1:0] stub_a, stub_b, stub_c;
  int               stub_cnt = 0;

  task automatic check(input string name, input logic [WIDTH-1:0] act,
                       input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r = '0;
    logic [WIDTH-1:0] x = a;
    for (int i = 0; i < WIDTH; i++) begin
      if (b[i]) r = r ^ x;
      x = x[WIDTH-1] ? ((x << 1) ^ POLY_LOW) : (x << 1);
    end
    return r;
  endfunction

  function automatic int lat_of(input int n);
    if (n == 0) return 2;
`ifdef GF2M_DOT_PREFETCH_EN
    return 3 + n * (LM + 1);
`else
    return 2 + n * (LM + 2);
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Operand memory.
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.rd_a_data <= mem_a[bus.rd_addr[2:0]];
      bus.rd_b_data <= mem_b[bus.rd_addr[2:0]];
    end
  end

  // Stub multiplier. inj_done injects a stale completion with a garbage product.
  always @(posedge clk) begin
    stub_done <= 1'b0;
    if (rst) begin
      stub_cnt <= 0;
    end else begin
      if (stub_cnt == 1) begin
        stub_done <= 1'b1;
        stub_c    <= gf_mul(stub_a, stub_b);
      end
      if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
      if (bus.mul_start) begin
        stub_a   <= bus.mul_op_a;
        stub_b   <= bus.mul_op_b;
        stub_cnt <= LM - 2;
      end
    end
  end
  assign bus.mul_done = stub_done | inj_done;
  assign bus.mul_op_c = inj_done ? {WIDTH{1'b1}} : stub_c;

  // Monitor.
  always @(negedge clk) begin
    if (rst) begin
      rd_seen = 0;
      ms_seen = 0;
    end else begin
      if (bus.rd_en) begin
        check("rd_addr", WIDTH'(bus.rd_addr), WIDTH'(rd_seen));
        rd_seen++;
      end
      if (bus.mul_start) ms_seen++;
      if (stub_done) begin
        check("op_a_stable", bus.mul_op_a, stub_a);
        check("op_b_stable", bus.mul_op_b, stub_b);
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done with result %0h, expected no done", bus.result);
        end else begin
          e = sb.pop_front();
          check("result", bus.result, e.res);
          if (e.lat >= 0) check("latency", WIDTH'(cyc - e.t0), WIDTH'(e.lat));
          check("rd_count", WIDTH'(rd_seen), WIDTH'(e.nrd));
          check("mul_start_count", WIDTH'(ms_seen), WIDTH'(e.nms));
          rd_seen = 0;
          ms_seen = 0;
        end
      end
    end
  end

  task automatic run(input int n, input logic [WIDTH-1:0] exp_res, input int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = ADDR_W'(n);
    sb.push_back('{exp_res, cyc, lat, n, n});
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = '0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (sb.size() != 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout: %0d results pending after %0d cycles, expected 0", name, sb.size(), k);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_ms(input int n);
    int k = 0;
    while (ms_seen < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (ms_seen < n) begin
      failures++;
      $display("FAIL wait_mul_start: got %0d mul_start pulses, expected %0d", ms_seen, n);
    end
  endtask

  task automatic check_reset();
    check("rst_busy", WIDTH'(bus.busy), '0);
    check("rst_done", WIDTH'(bus.done), '0);
    check("rst_rd_en", WIDTH'(bus.rd_en), '0);
    check("rst_mul_start", WIDTH'(bus.mul_start), '0);
    check("rst_rd_addr", WIDTH'(bus.rd_addr), '0);
    check("rst_result", bus.result, '0);
    check("rst_mul_op_a", bus.mul_op_a, '0);
    check("rst_mul_op_b", bus.mul_op_b, '0);
  endtask

  task automatic load(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    mem_a[i] = a;
    mem_b[i] = b;
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.len   = '0;
    inj_done  = 1'b0;
    for (int i = 0; i < 8; i++) load(i, '0, '0);
    repeat (3) @(negedge clk);
    check_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // len = 0: done two cycles after start, result 0, no reads or multiplies.
    run(0, '0, 2);
    wait_drain("len0");

    // len = 1: 1 * x = x.
    load(0, 83'h1, 83'h2);
    run(1, 83'h2, lat_of(1));
    wait_drain("len1");

    // len = 3: x^83 -> 0x95, (x+1)(x^2+1) -> 0xF, x^85 -> 0x254; sum 0x2CE.
    load(0, 83'h1 << 82, 83'h2);
    load(1, 83'h3, 83'h5);
    load(2, 83'h1 << 80, 83'h20);
    run(3, 83'h2CE, lat_of(3));
    wait_drain("len3");

    // len = 4, LM = 8: 0x95 ^ 0x9 ^ 0x100 ^ 0 = 0x19C.
    load(0, 83'h1 << 41, 83'h1 << 42);
    load(1, 83'h7, 83'h3);
    load(2, 83'h10, 83'h10);
    load(3, 83'h1, 83'h0);
`ifdef GF2M_DOT_PREFETCH_EN
    run(4, 83'h19C, 39);
`else
    run(4, 83'h19C, 42);
`endif
    wait_drain("len4");

    // len = 5 with start pulsed again (len 2) during WAIT; must be ignored.
    for (int i = 0; i < 5; i++) load(i, 83'h1, WIDTH'(1 << i));
    run(5, 83'h1F, lat_of(5));
    wait_ms(2);
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = ADDR_W'(2);
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = '0;
    wait_drain("restart_ignored");

    // Reset during WAIT of element 2, then a stale mul_done, then len = 2.
    run(5, 83'h0, -1);
    wait_ms(3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_reset();
    rst = 1'b0;
    @(negedge clk);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    load(0, 83'h1 << 82, 83'h2);
    load(1, 83'h1 << 82, 83'h4);
    // x^83 = 0x95, x^84 = 0x12A; sum 0x1BF.
    run(2, 83'h1BF, lat_of(2));
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    wait_drain("after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
